// File: rtl/board_pixel_pipe_if.sv
// Pixel, memory and overlay signals of the board pixel pipe.
// The master side is the VGA timing / memory / game-state side; the slave side is the pipe.
interface board_pixel_pipe_if #(
    parameter int ADDR_W = 7,
    parameter int SPR_W  = 12,
    parameter int CELL_W = 2,
    parameter int RGB_W  = 3
);
    logic              pix_valid;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              frame_start;
    logic [ADDR_W-1:0] board_addr;
    logic [CELL_W-1:0] board_data;
    logic [SPR_W-1:0]  sprite_addr;
    logic [RGB_W-1:0]  sprite_data;
    logic              win_valid;
    logic [7:0]        win_x0;
    logic [7:0]        win_y0;
    logic [1:0]        win_dir;
    logic              cur_en;
    logic [7:0]        cur_x;
    logic [7:0]        cur_y;
    logic              rgb_valid;
    logic [RGB_W-1:0]  rgb;

    modport master (
        output pix_valid, x, y, frame_start, board_data, sprite_data,
               win_valid, win_x0, win_y0, win_dir, cur_en, cur_x, cur_y,
        input  board_addr, sprite_addr, rgb_valid, rgb
    );

    modport slave (
        input  pix_valid, x, y, frame_start, board_data, sprite_data,
               win_valid, win_x0, win_y0, win_dir, cur_en, cur_x, cur_y,
        output board_addr, sprite_addr, rgb_valid, rgb
    );
endinterface

// File: rtl/board_pixel_pipe.sv
// Board-region pixel generator: cell lookup, sprite fetch, then win-line and cursor overlay.
// Fixed latency of MEM_LAT+1 cycles, one pixel per cycle.
module board_pixel_pipe #(
    parameter int               TILE_LOG2    = 5,
    parameter int               BOARD_COLS   = 10,
    parameter int               BOARD_ROWS   = 10,
    parameter int               ORIGIN_X     = 176,
    parameter int               ORIGIN_Y     = 32,
    parameter int               CELL_W       = 2,
    parameter int               RGB_W        = 3,
    parameter int               MEM_LAT      = 1,
    parameter int               WIN_LEN      = 4,
    parameter int               STRIPE_HW    = 2,
    parameter int               CUR_W        = 2,
    parameter int               BLINK_FRAMES = 16,
    parameter logic [RGB_W-1:0] BG_RGB       = 3'b111,
    parameter logic [RGB_W-1:0] WIN_RGB      = 3'b100,
    parameter logic [RGB_W-1:0] CUR_RGB      = 3'b001
) (
    input logic               clk,
    input logic               rst_n,
    board_pixel_pipe_if.slave bus
);
    localparam int ADDR_W = $clog2(BOARD_COLS * BOARD_ROWS);
    localparam int SPR_W  = CELL_W + 2 * TILE_LOG2;
    localparam int TILE   = 1 << TILE_LOG2;
    localparam int HALF   = TILE / 2;

    localparam logic [15:0]          X_LO     = 16'(ORIGIN_X);
    localparam logic [15:0]          Y_LO     = 16'(ORIGIN_Y);
    localparam logic [15:0]          X_SPAN   = 16'(BOARD_COLS * TILE);
    localparam logic [15:0]          Y_SPAN   = 16'(BOARD_ROWS * TILE);
    localparam logic [TILE_LOG2-1:0] CUR_LO   = TILE_LOG2'(CUR_W);
    localparam logic [TILE_LOG2-1:0] CUR_HI   = TILE_LOG2'(TILE - CUR_W);
    localparam logic [7:0]           CNT_WRAP = 8'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic                 valid;
        logic                 in_board;
        logic [TILE_LOG2-1:0] tx;
        logic [TILE_LOG2-1:0] ty;
        logic                 win_hit;
        logic                 cur_hit;
    } side_t;

    logic             r_win_valid;
    logic [7:0]       r_win_x0;
    logic [7:0]       r_win_y0;
    logic [1:0]       r_win_dir;
    logic             r_cur_en;
    logic [7:0]       r_cur_x;
    logic [7:0]       r_cur_y;
    logic [7:0]       r_frame_cnt;
    logic             r_blink_on;

    logic [ADDR_W-1:0] r_board_addr;
    logic [SPR_W-1:0]  r_sprite_addr;
    side_t             r_dly [MEM_LAT];
    logic              r_c_valid;
    logic              r_c_in_board;
    logic              r_c_win;
    logic              r_c_cur;
    logic              r_rgb_valid;
    logic [RGB_W-1:0]  r_rgb;

    logic [15:0]          w_off_x;
    logic [15:0]          w_off_y;
    logic                 w_in_board;
    logic [8:0]           w_col;
    logic [8:0]           w_row;
    logic [TILE_LOG2-1:0] w_tx;
    logic [TILE_LOG2-1:0] w_ty;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_stripe;
    logic                 w_on_line;
    logic [8:0]           w_step_x;
    logic [8:0]           w_step_y;
    logic                 w_cur_edge;
    side_t                w_side;
    side_t                w_dly_out;
    logic [RGB_W-1:0]     w_pix_rgb;

    // Overlay state only changes at frame boundaries so a frame is drawn with one consistent view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_x0    <= '0;
            r_win_y0    <= '0;
            r_win_dir   <= '0;
            r_cur_en    <= 1'b0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (bus.frame_start) begin
            r_win_valid <= bus.win_valid;
            r_win_x0    <= bus.win_x0;
            r_win_y0    <= bus.win_y0;
            r_win_dir   <= bus.win_dir;
            r_cur_en    <= bus.cur_en;
            r_cur_x     <= bus.cur_x;
            r_cur_y     <= bus.cur_y;
            if (!bus.win_valid || !r_win_valid) begin
                r_frame_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (r_frame_cnt == CNT_WRAP) begin
                r_frame_cnt <= '0;
                r_blink_on  <= !r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign w_off_x    = bus.x - X_LO;
    assign w_off_y    = bus.y - Y_LO;
    assign w_in_board = (bus.x >= X_LO) && (w_off_x < X_SPAN) && (bus.y >= Y_LO) && (w_off_y < Y_SPAN);
    assign w_col      = 9'(w_off_x >> TILE_LOG2);
    assign w_row      = 9'(w_off_y >> TILE_LOG2);
    assign w_tx       = w_off_x[TILE_LOG2-1:0];
    assign w_ty       = w_off_y[TILE_LOG2-1:0];
    assign w_addr     = ADDR_W'(int'(w_row) * BOARD_COLS + int'(w_col));

    assign w_step_x = (r_win_dir == 2'b01) ? 9'd0 : (r_win_dir == 2'b11) ? 9'h1FF : 9'd1;
    assign w_step_y = (r_win_dir == 2'b00) ? 9'd0 : 9'd1;

    // NOTE: every variable gets its default before any branch, so no latch can be inferred.
    always_comb begin
        int d;
        w_stripe = 1'b0;
        case (r_win_dir)
            2'b00:   d = int'(w_ty) - HALF;
            2'b01:   d = int'(w_tx) - HALF;
            2'b10:   d = int'(w_tx) - int'(w_ty);
            default: d = int'(w_tx) + int'(w_ty) - (TILE - 1);
        endcase
        w_stripe = (d <= STRIPE_HW) && (d >= -STRIPE_HW);
    end

    // Line cells are walked in 9-bit arithmetic; cells that leave the board never match a pixel cell.
    always_comb begin
        logic [8:0] cx;
        logic [8:0] cy;
        w_on_line = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) begin
            cx = {1'b0, r_win_x0} + 9'(i) * w_step_x;
            cy = {1'b0, r_win_y0} + 9'(i) * w_step_y;
            if (cx == w_col && cy == w_row) w_on_line = 1'b1;
        end
    end

    assign w_cur_edge = (w_tx < CUR_LO) || (w_tx >= CUR_HI) || (w_ty < CUR_LO) || (w_ty >= CUR_HI);

    always_comb begin
        w_side          = '0;
        w_side.valid    = bus.pix_valid;
        w_side.in_board = w_in_board;
        w_side.tx       = w_tx;
        w_side.ty       = w_ty;
        w_side.win_hit  = r_win_valid && r_blink_on && w_on_line && w_stripe;
        w_side.cur_hit  = r_cur_en && (w_col == {1'b0, r_cur_x}) && (w_row == {1'b0, r_cur_y}) && w_cur_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board_addr <= '0;
        end else if (bus.pix_valid && w_in_board) begin
            r_board_addr <= w_addr;
        end
    end

    // NOTE: the delay line is only a few entries, so it is reset in full; its valid bits must clear to drop in-flight pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_side;
            for (int i = 1; i < MEM_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_dly_out = r_dly[MEM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sprite_addr <= '0;
            r_c_valid     <= 1'b0;
            r_c_in_board  <= 1'b0;
            r_c_win       <= 1'b0;
            r_c_cur       <= 1'b0;
        end else begin
            r_c_valid    <= w_dly_out.valid;
            r_c_in_board <= w_dly_out.in_board;
            r_c_win      <= w_dly_out.win_hit;
            r_c_cur      <= w_dly_out.cur_hit;
            if (w_dly_out.valid && w_dly_out.in_board)
                r_sprite_addr <= {bus.board_data, w_dly_out.ty, w_dly_out.tx};
        end
    end

    always_comb begin
        w_pix_rgb = bus.sprite_data;
        if (!r_c_in_board)  w_pix_rgb = BG_RGB;
        else if (r_c_win)   w_pix_rgb = WIN_RGB;
        else if (r_c_cur)   w_pix_rgb = CUR_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_valid <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_rgb_valid <= r_c_valid;
            if (r_c_valid) r_rgb <= w_pix_rgb;
        end
    end

    assign bus.board_addr  = r_board_addr;
    assign bus.sprite_addr = r_sprite_addr;
    assign bus.rgb_valid   = r_rgb_valid;
    assign bus.rgb         = r_rgb;
endmodule

// File: tb/tb_board_pixel_pipe.sv
// Directed bench for board_pixel_pipe: addressing, background, win stripe, blink, cursor, mid-stream reset.
// Board and sprite memories are modelled here with zero-wait lookups on the registered addresses.
module tb_board_pixel_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       use_fn;
    logic [1:0] bd_const;
    logic [2:0] sd_const;

    board_pixel_pipe_if #(.ADDR_W(7), .SPR_W(12), .CELL_W(2), .RGB_W(3)) bus ();

    board_pixel_pipe #(.BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] cell_fn(input logic [6:0] a);
        logic [6:0] t;
        t = a * 7'd3 + 7'd1;
        return t[1:0];
    endfunction

    function automatic logic [2:0] spr_fn(input logic [11:0] s);
        return s[2:0] ^ s[7:5] ^ {1'b0, s[11:10]};
    endfunction

    assign bus.board_data  = use_fn ? cell_fn(bus.board_addr) : bd_const;
    assign bus.sprite_data = use_fn ? spr_fn(bus.sprite_addr) : sd_const;

    function automatic logic [2:0] exp_stream(input int px, input int py);
        int         col, row, tx, ty;
        logic [6:0] a;
        logic [1:0] c;
        logic [11:0] sa;
        col = (px - 176) / 32;
        tx  = (px - 176) % 32;
        row = (py - 32) / 32;
        ty  = (py - 32) % 32;
        a   = 7'(row * 10 + col);
        c   = cell_fn(a);
        sa  = {c, 5'(ty), 5'(tx)};
        return spr_fn(sa);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int px, input int py);
        bus.pix_valid = 1'b1;
        bus.x         = 16'(px);
        bus.y         = 16'(py);
    endtask

    // Sends one pixel and samples the output two edges after it was taken.
    task automatic pix_check(input string tag, input int px, input int py, input logic [2:0] exp);
        drive(px, py);
        step();
        bus.pix_valid = 1'b0;
        step();
        step();
        check(tag, 32'(bus.rgb), 32'(exp));
        check({tag, "_v"}, 32'(bus.rgb_valid), 32'd1);
    endtask

    task automatic set_frame(input logic wv, input int wx, input int wy, input logic [1:0] wd,
                             input logic ce, input int cx, input int cy);
        bus.win_valid   = wv;
        bus.win_x0      = 8'(wx);
        bus.win_y0      = 8'(wy);
        bus.win_dir     = wd;
        bus.cur_en      = ce;
        bus.cur_x       = 8'(cx);
        bus.cur_y       = 8'(cy);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] blink_exp [5];
        logic [2:0] stream_exp [100];
        int px, py;

        blink_exp[0] = 3'b100;
        blink_exp[1] = 3'b100;
        blink_exp[2] = 3'b010;
        blink_exp[3] = 3'b010;
        blink_exp[4] = 3'b100;

        use_fn = 1'b0;
        bd_const = 2'd2;
        sd_const = 3'b010;
        bus.pix_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.frame_start = 1'b0;
        bus.win_valid = 1'b0;
        bus.win_x0 = '0;
        bus.win_y0 = '0;
        bus.win_dir = '0;
        bus.cur_en = 1'b0;
        bus.cur_x = '0;
        bus.cur_y = '0;
        rst_n = 1'b0;
        step();
        step();
        check("rst_rgb", 32'(bus.rgb), 32'd0);
        check("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        check("rst_board_addr", 32'(bus.board_addr), 32'd0);
        check("rst_sprite_addr", 32'(bus.sprite_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Pixel (277,103): cell (3,2), tx=5, ty=7.
        drive(277, 103);
        step();
        check("t1_board_addr", 32'(bus.board_addr), 32'd23);
        bus.pix_valid = 1'b0;
        step();
        check("t1_sprite_addr", 32'(bus.sprite_addr), 32'd2277);
        check("t1_early_valid", 32'(bus.rgb_valid), 32'd0);
        step();
        check("t1_rgb", 32'(bus.rgb), 32'b010);
        check("t1_rgb_valid", 32'(bus.rgb_valid), 32'd1);
        step();
        check("t1_hold_valid", 32'(bus.rgb_valid), 32'd0);
        check("t1_hold_rgb", 32'(bus.rgb), 32'b010);

        pix_check("bg_left", 175, 40, 3'b111);
        check("bg_left_baddr", 32'(bus.board_addr), 32'd23);
        check("bg_left_saddr", 32'(bus.sprite_addr), 32'd2277);
        pix_check("bg_right", 496, 40, 3'b111);
        check("bg_right_baddr", 32'(bus.board_addr), 32'd23);
        check("bg_right_saddr", 32'(bus.sprite_addr), 32'd2277);

        // Diagonal win from (8,8): (9,9) is on the line, (10,10) and beyond fall off the board.
        set_frame(1'b0, 0, 0, 2'b00, 1'b0, 0, 0);
        set_frame(1'b1, 8, 8, 2'b10, 1'b0, 0, 0);
        pix_check("diag_centre", 480, 336, 3'b100);
        pix_check("diag_offstripe", 464, 351, 3'b010);
        pix_check("diag_corner", 495, 351, 3'b100);
        pix_check("diag_offboard", 496, 352, 3'b111);

        set_frame(1'b0, 0, 0, 2'b00, 1'b0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            set_frame(1'b1, 8, 8, 2'b10, 1'b0, 0, 0);
            pix_check($sformatf("blink_%0d", p), 480, 336, blink_exp[p]);
        end

        // Anti-diagonal from (9,0): cells (9,0),(8,1),(7,2),(6,3) only.
        set_frame(1'b0, 0, 0, 2'b00, 1'b0, 0, 0);
        set_frame(1'b1, 9, 0, 2'b11, 1'b0, 0, 0);
        pix_check("anti_last_cell", 399, 128, 3'b100);
        pix_check("anti_offstripe", 384, 128, 3'b010);
        pix_check("anti_past_len", 367, 160, 3'b010);

        set_frame(1'b0, 0, 0, 2'b00, 1'b1, 0, 0);
        pix_check("cur_edge", 177, 40, 3'b001);
        pix_check("cur_inner", 192, 48, 3'b010);
        pix_check("cur_far_edge", 207, 63, 3'b001);
        set_frame(1'b1, 0, 0, 2'b00, 1'b1, 0, 0);
        pix_check("win_over_cur", 177, 48, 3'b100);

        // Continuous stream with an asynchronous reset pulse just before pixel 50 is taken.
        set_frame(1'b0, 0, 0, 2'b00, 1'b0, 0, 0);
        use_fn = 1'b1;
        step();
        step();
        for (int i = 0; i < 100; i++) begin
            px = 176 + (i * 37) % 320;
            py = 32 + (i * 53) % 320;
            stream_exp[i] = exp_stream(px, py);
        end
        for (int e = 0; e < 102; e++) begin
            if (e == 50) begin
                rst_n = 1'b0;
                #1;
                check("rst_async_valid", 32'(bus.rgb_valid), 32'd0);
                check("rst_async_rgb", 32'(bus.rgb), 32'd0);
                #2;
                rst_n = 1'b1;
            end
            if (e < 100) drive(176 + (e * 37) % 320, 32 + (e * 53) % 320);
            else bus.pix_valid = 1'b0;
            step();
            if (e < 2 || e == 50 || e == 51) begin
                check($sformatf("stream_idle_%0d", e), 32'(bus.rgb_valid), 32'd0);
            end else begin
                check($sformatf("stream_valid_%0d", e), 32'(bus.rgb_valid), 32'd1);
                check($sformatf("stream_rgb_%0d", e), 32'(bus.rgb), 32'(stream_exp[e-2]));
            end
        end
        bus.pix_valid = 1'b0;
        step();
        check("stream_drain", 32'(bus.rgb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
